regfile_rat: RTL
================

# regfile_rat

Architectural register file with per-register rename tags, sitting directly downstream of the ROB commit port and upstream of the issue/reservation-station stage. It records which ROB entry will produce each register at issue, writes committed values from the ROB commit bus, and supplies source operands as either a ready value or a pending ROB tag. Thirty-two 32-bit registers; x0 is hardwired to zero.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers (index width 5).
- ROB_IDX_W, 5, ROB tag width (32-entry ROB).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue  in  1  an instruction is being issued this cycle.
- DR_entry_issue  in  5  destination register of the issuing instruction.
- issue_rob_idx  in  5  ROB entry allocated to the issuing instruction.
- rob_regfile_bus  in  rob_entry_structs::rob_to_regfile  commit bus: valid, value[31:0], rob_idx[4:0], regfile_idx[4:0].
- flush  in  1  pipeline flush: discard all pending renames.
- rs1_idx, rs2_idx  in  5 each  source register indices.
- rs1_value, rs2_value  out  32 each  register value (valid when busy=0).
- rs1_busy, rs2_busy  out  1 each  register awaits a ROB result.
- rs1_tag, rs2_tag  out  5 each  ROB entry that will produce the register (valid when busy=1).

## Operation
- State per register r: value[r] (32b), busy[r] (1b), tag[r] (5b).
- Issue (issue=1, DR_entry_issue≠0): next cycle busy[DR]=1, tag[DR]=issue_rob_idx. DR=0: no state change.
- Commit (rob_regfile_bus.valid=1, regfile_idx≠0): value[regfile_idx] ← value always written. busy cleared only if tag[regfile_idx]==rob_idx (no younger rename outstanding); otherwise busy/tag unchanged.
- Commit and issue to same register, same cycle: value written; busy=1, tag=issue_rob_idx (issue wins).
- Commit and issue to different registers, same cycle: both applied independently.
- Flush=1: all busy bits cleared, tags unchanged (don't-care), values unchanged; a commit in the same cycle still writes its value; an issue in the same cycle is dropped.
- Reads are combinational from state (plus bypass, see Configuration). Reads reflect state before the same-cycle issue: an instruction reading and writing the same register sees the old mapping.
- x0: rsN_value=0, rsN_busy=0, rsN_tag=0 regardless of state.
- Reset: all value=0, busy=0, tag=0; hence all outputs 0 after reset.

## Timing
- Issue → rename visible on read ports: 1 cycle (next posedge).
- Commit → value visible: 0 cycles with bypass enabled, 1 cycle without.
- Flush → all reads busy=0: next cycle.
- rst has priority over flush, issue and commit in the same cycle; reset asserted mid-operation discards every pending rename.
- No backpressure: block accepts one issue and one commit every cycle.

## Configuration
- REGFILE_COMMIT_BYPASS_EN defined: if rob_regfile_bus.valid, regfile_idx==rsN_idx≠0 and tag[rsN_idx]==rob_idx with busy set, rsN outputs value=bus value, busy=0 in the same cycle. If tag mismatches, no bypass (register still busy on younger tag).
- Undefined: read ports show registered state only; committed values appear the cycle after commit.

## Test plan
- Reset held 5 cycles → all rs1/rs2 reads of x1..x31 return value=0, busy=0, tag=0.
- Issue DR=3, rob_idx=0; next cycle read rs1=3 → busy=1, tag=0; commit {valid, value=156, rob_idx=0, regfile_idx=3} → value=156, busy=0 (same cycle with bypass, next cycle without).
- Issue DR=5 rob 4, then DR=5 rob 9; commit rob 4 value 205 → value[5]=205 but busy=1, tag=9; commit rob 9 value 209 → busy=0, value=209.
- Same cycle: issue DR=7 rob 12 and commit regfile_idx=7 rob_idx=2 value 207 (prior tag 2) → next cycle busy=1, tag=12, value=207.
- Issue DR=0 rob 1 and commit regfile_idx=0 value 99 → rs1=0 reads value=0, busy=0.
- Issue 31 registers x1..x31 with rob tags 1..31, assert flush → next cycle all busy=0, values unchanged; issue in flush cycle not recorded.

Source files
------------

// File: rtl/regfile_rat.sv
// Architectural register file with per-register ROB rename tags; x0 reads as zero.
// Define REGFILE_COMMIT_BYPASS_EN to forward a matching commit onto the read ports in the same cycle.
package rob_entry_structs;
    typedef struct packed {
        logic        valid;
        logic [31:0] value;
        logic [4:0]  rob_idx;
        logic [4:0]  regfile_idx;
    } rob_to_regfile;
endpackage

module regfile_rat #(
    parameter int NUM_REGS  = 32,
    parameter int ROB_IDX_W = 5,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue,
    input  logic [IDX_W-1:0]               DR_entry_issue,
    input  logic [ROB_IDX_W-1:0]           issue_rob_idx,
    input  rob_entry_structs::rob_to_regfile rob_regfile_bus,
    input  logic                           flush,
    input  logic [IDX_W-1:0]               rs1_idx,
    input  logic [IDX_W-1:0]               rs2_idx,
    output logic [31:0]                    rs1_value,
    output logic [31:0]                    rs2_value,
    output logic                           rs1_busy,
    output logic                           rs2_busy,
    output logic [ROB_IDX_W-1:0]           rs1_tag,
    output logic [ROB_IDX_W-1:0]           rs2_tag
);

    typedef struct packed {
        logic [31:0]          value;
        logic                 busy;
        logic [ROB_IDX_W-1:0] tag;
    } rd_t;

    logic [31:0]          value_q [NUM_REGS];
    logic [31:0]          value_d [NUM_REGS];
    logic [ROB_IDX_W-1:0] tag_q   [NUM_REGS];
    logic [ROB_IDX_W-1:0] tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;

    logic commit_en;
    logic issue_en;
    assign commit_en = rob_regfile_bus.valid && (rob_regfile_bus.regfile_idx != '0);
    assign issue_en  = issue && (DR_entry_issue != '0);

    // Commit is applied first so a same-register issue overrides its busy/tag update.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_en) begin
            value_d[rob_regfile_bus.regfile_idx] = rob_regfile_bus.value;
            if (tag_q[rob_regfile_bus.regfile_idx] == rob_regfile_bus.rob_idx) begin
                busy_d[rob_regfile_bus.regfile_idx] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (issue_en) begin
            busy_d[DR_entry_issue] = 1'b1;
            tag_d[DR_entry_issue]  = issue_rob_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    function automatic rd_t read_port(input logic [IDX_W-1:0] idx);
        rd_t r;
        r.value = value_q[idx];
        r.busy  = busy_q[idx];
        r.tag   = tag_q[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (rob_regfile_bus.valid && (rob_regfile_bus.regfile_idx == idx) &&
            busy_q[idx] && (tag_q[idx] == rob_regfile_bus.rob_idx)) begin
            r.value = rob_regfile_bus.value;
            r.busy  = 1'b0;
        end
`endif
        if (idx == '0) begin
            r = '0;
        end
        return r;
    endfunction

    rd_t rd1;
    rd_t rd2;

    always_comb begin
        rd1 = read_port(rs1_idx);
        rd2 = read_port(rs2_idx);
    end

    assign rs1_value = rd1.value;
    assign rs1_busy  = rd1.busy;
    assign rs1_tag   = rd1.tag;
    assign rs2_value = rd2.value;
    assign rs2_busy  = rd2.busy;
    assign rs2_tag   = rd2.tag;

endmodule
